// File: rtl/decode_regfile_sb_pkg.sv
// Shared core constants for the decode-stage register file and scoreboard.
// Holds the architectural register count, data width and the derived
// register-address width that decode and the register file must agree on.
package decode_regfile_sb_pkg;

  localparam int DEF_DATA_W = 32;                  // register width in bits
  localparam int DEF_NREGS  = 32;                  // architectural register count
  localparam int DEF_NRD    = 2;                   // combinational read ports
  localparam int DEF_AW     = $clog2(DEF_NREGS);   // register address width

endpackage

// File: rtl/decode_regfile_sb_if.sv
// Decode <-> register file bus.
// Carries the read ports (addresses, source enables, data, busy flags), the
// issue handshake (valid/wr/dst/ready), the writeback port and the
// scoreboard observation outputs.
//   master : decode side (drives addresses, issue request, writeback)
//   slave  : register file / scoreboard (drives data, busy, ready, pending)
interface decode_regfile_sb_if
  import decode_regfile_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = DEF_NRD
);
  localparam int AW = $clog2(NREGS);

  // read ports, port i at [i*AW +: AW] / [i*DATA_W +: DATA_W]
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD-1:0]        rd_src_en;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;

  // issue handshake
  logic                  iss_valid;
  logic                  iss_wr;
  logic [AW-1:0]         iss_dst;
  logic                  iss_ready;

  // writeback
  logic                  wb_en;
  logic [AW-1:0]         wb_addr;
  logic [DATA_W-1:0]     wb_data;

  // scoreboard observation
  logic [NREGS-1:0]      pending_vec;
  logic [AW:0]           pending_cnt;

  modport master (
    output rd_addr, rd_src_en, iss_valid, iss_wr, iss_dst,
           wb_en, wb_addr, wb_data,
    input  rd_data, rd_busy, iss_ready, pending_vec, pending_cnt
  );

  modport slave (
    input  rd_addr, rd_src_en, iss_valid, iss_wr, iss_dst,
           wb_en, wb_addr, wb_data,
    output rd_data, rd_busy, iss_ready, pending_vec, pending_cnt
  );

endinterface

// File: rtl/decode_regfile_sb_rdport.sv
// One combinational register-file read port with writeback bypass and
// scoreboard busy lookup.
// Ports:
//   flush_n  : active-low reset, forces data to 0 while asserted
//   addr     : register address for this port
//   regs     : flattened register storage
//   pending  : scoreboard bits
//   wb_en/wb_addr/wb_data : writeback port, forwarded when it hits addr
//   data     : read data (0 for register 0)
//   busy     : source has an outstanding writer not resolved this cycle
module regfile_rdport #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5
) (
  input  logic                         flush_n,
  input  logic [AW-1:0]                addr,
  input  logic [NREGS-1:0][DATA_W-1:0] regs,
  input  logic [NREGS-1:0]             pending,
  input  logic                         wb_en,
  input  logic [AW-1:0]                wb_addr,
  input  logic [DATA_W-1:0]            wb_data,
  output logic [DATA_W-1:0]            data,
  output logic                         busy
);

  logic addr_nz;
  logic wb_hit;

  assign addr_nz = (addr != '0);
  assign wb_hit  = wb_en && (wb_addr == addr);

  always_comb begin
    data = '0;
    // Storage is already cleared in reset; the gate also masks a bypass
    // that would otherwise leak wb_data through while reset is held.
    if (flush_n && addr_nz) begin
      data = wb_hit ? wb_data : regs[addr];
    end
  end

  // A writer retiring this very cycle resolves the hazard.
  assign busy = addr_nz && pending[addr] && !wb_hit;

endmodule

// File: rtl/decode_regfile_sb.sv
// Decode-stage register file with write-through bypass and a scoreboard of
// in-flight destination registers.
// Ports:
//   clk     : clock, rising edge
//   flush_n : asynchronous active-low reset (registers, scoreboard, count)
//   pflush  : synchronous pipeline flush; drops all pending bits, blocks issue
//   bus     : decode_regfile_sb_if slave (read ports, issue, writeback,
//             pending_vec / pending_cnt observation)
module decode_regfile_sb
  import decode_regfile_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = DEF_NRD
) (
  input  logic                 clk,
  input  logic                 flush_n,
  input  logic                 pflush,
  decode_regfile_sb_if.slave   bus
);

  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0][DATA_W-1:0] regs_q;
  logic [NREGS-1:0]             pending_q;
  logic [NREGS-1:0]             pending_next;
  logic [AW:0]                  cnt_q;
  logic [AW:0]                  cnt_next;
  logic                         src_stall;
  logic                         dst_wb_hit;
  logic                         waw_stall;
  logic                         fire;

  // ---------------------------------------------------------------------
  // Register storage; register 0 is never written and reads back as 0.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge flush_n) begin
    if (!flush_n) begin
      regs_q <= '0;
    end else if (bus.wb_en && (bus.wb_addr != '0)) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // ---------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    regfile_rdport #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .AW     (AW)
    ) u_rdport (
      .flush_n (flush_n),
      .addr    (bus.rd_addr[gi*AW +: AW]),
      .regs    (regs_q),
      .pending (pending_q),
      .wb_en   (bus.wb_en),
      .wb_addr (bus.wb_addr),
      .wb_data (bus.wb_data),
      .data    (bus.rd_data[gi*DATA_W +: DATA_W]),
      .busy    (bus.rd_busy[gi])
    );
  end

  // ---------------------------------------------------------------------
  // Issue gating: RAW on any enabled source, WAW on the destination.
  // ---------------------------------------------------------------------
  assign src_stall  = |(bus.rd_src_en & bus.rd_busy);
  assign dst_wb_hit = bus.wb_en && (bus.wb_addr == bus.iss_dst);
  assign waw_stall  = bus.iss_wr && (bus.iss_dst != '0) &&
                      pending_q[bus.iss_dst] && !dst_wb_hit;

  assign bus.iss_ready = !pflush && !src_stall && !waw_stall;
  assign fire          = bus.iss_valid && bus.iss_ready && bus.iss_wr &&
                         (bus.iss_dst != '0);

  // ---------------------------------------------------------------------
  // Scoreboard next state. Order matters: the clear from writeback is
  // applied first so a same-register issue overrides it, and pflush wins
  // over everything (fire is already blocked by pflush).
  // ---------------------------------------------------------------------
  always_comb begin
    pending_next = pending_q;
    if (bus.wb_en) begin
      pending_next[bus.wb_addr] = 1'b0;
    end
    if (fire) begin
      pending_next[bus.iss_dst] = 1'b1;
    end
    if (pflush) begin
      pending_next = '0;
    end
    pending_next[0] = 1'b0;
  end

  // Count is taken from the next-state vector so the registered count
  // always matches the registered vector.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_next = cnt_next + (AW+1)'(pending_next[i]);
    end
  end

  always_ff @(posedge clk or negedge flush_n) begin
    if (!flush_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_next;
      cnt_q     <= cnt_next;
    end
  end

  assign bus.pending_vec = pending_q;
  assign bus.pending_cnt = cnt_q;

endmodule

// File: doc/decode_regfile_sb.md
DECODE_REGFILE_SB -- requirements
Module: decode_regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning architectural register count; AW = $clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, meaning number of combinational read ports (1..4).
REQ-004 SHALL provide the ports below (clock and reset first); all ports use one clock, and reset is asynchronous and active-low:
- clk  in  1  clock, rising edge.
- flush_n  in  1  asynchronous active-low reset.
- pflush  in  1  synchronous pipeline flush.
- rd_addr  in  NRD*AW  read addresses; port i occupies [i*AW +: AW].
- rd_src_en  in  NRD  port i is a true source operand for hazard checking.
- rd_data  out  NRD*DATA_W  read data per port.
- rd_busy  out  NRD  port i source has a pending writer.
- iss_valid  in  1  decode presents an instruction.
- iss_wr  in  1  the instruction writes a destination.
- iss_dst  in  AW  destination register.
- iss_ready  out  1  the instruction may issue this cycle.
- wb_en  in  1  writeback valid.
- wb_addr  in  AW  writeback register.
- wb_data  in  DATA_W  writeback data.
- pending_vec  out  NREGS  scoreboard bits.
- pending_cnt  out  AW+1  popcount of pending_vec.

Function
REQ-005 SHALL write wb_data to reg[wb_addr] on the rising clk edge when wb_en=1 and wb_addr!=0.
REQ-006 SHALL return 0 on rd_data for address 0 regardless of any write.
REQ-007 SHALL bypass writeback combinationally: if wb_en=1 and wb_addr==rd_addr[i]!=0, rd_data[i]=wb_data in the same cycle.
REQ-008 SHALL compute rd_busy[i] = pending[rd_addr[i]] & ~(wb_en & wb_addr==rd_addr[i]); rd_busy is 0 for address 0.
REQ-009 SHALL assert iss_ready only when pflush=0, no i has rd_src_en[i]&rd_busy[i], and not (iss_wr & iss_dst!=0 & pending[iss_dst] & ~(wb_en & wb_addr==iss_dst)).
REQ-010 SHALL define issue fire as iss_valid & iss_ready & iss_wr & iss_dst!=0, and SHALL set pending[iss_dst] at the next edge on fire.
REQ-011 SHALL clear pending[wb_addr] at the edge when wb_en=1 and no fire targets the same register.
REQ-012 SHALL give set priority on the same cycle and register: fire and writeback both target r -> pending[r]=1 after the edge, and reg[r]=wb_data.
REQ-013 SHALL, on pflush=1, clear all pending bits at the edge, block issue, and still perform any wb_en write that cycle.
REQ-014 SHALL hold pending[0] at 0 permanently.
REQ-015 SHALL keep pending_cnt equal to the popcount of the registered pending_vec; pending_cnt is a registered value with no combinational path from inputs.
REQ-016 SHALL ignore writeback to a register that is not pending: the data is written and the scoreboard is unchanged.

Reset
REQ-017 SHALL, on flush_n=0, immediately clear all registers, pending_vec and pending_cnt to 0, independent of clk.
REQ-018 SHALL, during reset, drive rd_data=0, rd_busy=0 and iss_ready=1 while pflush=0.
REQ-019 SHALL resume normal operation on the first rising edge after flush_n deasserts; a reset asserted mid-operation discards all pending state.

Structure
REQ-020 SHALL place the decode-to-regfile address width and register count constants in the shared core package.
REQ-021 SHALL implement the read/bypass mux as one sub-module, regfile_rdport, instantiated NRD times through a generate loop.
REQ-022 SHALL keep the scoreboard and pending counter in the top module with no latches.

Verification
REQ-023 SHALL test write then read: wb r5=0xDEADBEEF at cycle 1; rd_addr0=5 shows 0xDEADBEEF in cycle 1 via bypass and in cycle 2 from storage.
REQ-024 SHALL test RAW stall: issue with dst=7; next cycle rd_src_en0=1, rd_addr0=7 -> rd_busy0=1, iss_ready=0; wb r7=0x12 -> iss_ready=1 in that same cycle and rd_data0=0x12.
REQ-025 SHALL test WAW: pending r3; issue with iss_wr=1, dst=3 -> iss_ready=0 until the r3 writeback cycle.
REQ-026 SHALL test simultaneous events: fire dst=9 and wb r9=0x55 in the same cycle -> pending[9]=1, reg9=0x55, pending_cnt unchanged.
REQ-027 SHALL test pflush: pending r1,r2,r4 (pending_cnt=3); pflush=1 with wb r2=0xAA -> iss_ready=0 that cycle; next cycle pending_vec=0, pending_cnt=0, reg2=0xAA.
REQ-028 SHALL test register 0 and reset: wb r0=0xFFFFFFFF -> rd_data=0 and pending[0] stays 0; flush_n pulsed low asynchronously mid-cycle -> all registers, pending_vec and pending_cnt read 0 immediately.
